// File: rtl/march_bist_ctrl_pkg.sv
// march_bist_ctrl_pkg: shared types, defaults and March C- element tables
package march_bist_ctrl_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;
    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_t;
    // Tables indexed by element number (bit 0 = E0).
    // RVAL/WVAL: 1 means the "1" pattern (~bg_pat), 0 means bg_pat.
    localparam logic [5:0] ELEM_DOWN = 6'b111000;
    localparam logic [5:0] ELEM_RD   = 6'b111110;
    localparam logic [5:0] ELEM_WR   = 6'b011111;
    localparam logic [5:0] ELEM_RVAL = 6'b010100;
    localparam logic [5:0] ELEM_WVAL = 6'b001010;
endpackage

// File: rtl/march_bist_ctrl_addr_gen.sv
// bist_addr_gen: loadable up/down address counter with last-address flag
//   i_load : load 0 (up) or all-ones (down) and latch direction i_down
//   i_step : step one address in the latched direction
//   o_addr : current address; o_last : current address is the final one for the direction
module bist_addr_gen #(
    parameter int ADDR_W = march_bist_ctrl_pkg::ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_down,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    logic [ADDR_W-1:0] r_addr;
    logic              r_down;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= '0;
            r_down <= 1'b0;
        end else if (i_load) begin
            r_addr <= i_down ? '1 : '0;
            r_down <= i_down;
        end else if (i_step) begin
            r_addr <= r_down ? r_addr - 1'b1 : r_addr + 1'b1;
        end
    end
    assign o_addr = r_addr;
    assign o_last = r_down ? (r_addr == '0) : (r_addr == '1);
endmodule

// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl: March C- memory BIST controller with user-port pass-through
//   i_start/i_abort/i_stop_on_fail/i_bg_pat : run control
//   i_usr_*  : user RAM port, forwarded to o_ram_* when not busy
//   o_ram_*/i_ram_rd_data : RAM port (read data one cycle after address)
//   o_busy/o_done/o_pass/o_fail : status; o_fail_* : first-miscompare record; o_fail_cnt : saturating count
module march_bist_ctrl
    import march_bist_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_stop_on_fail,
    input  logic [DATA_W-1:0] i_bg_pat,
    input  logic [ADDR_W-1:0] i_usr_rd_addrs,
    input  logic [ADDR_W-1:0] i_usr_wrt_addrs,
    input  logic [DATA_W-1:0] i_usr_wrt_dat,
    input  logic              i_usr_wrt_en,
    output logic [ADDR_W-1:0] o_ram_rd_addrs,
    output logic [ADDR_W-1:0] o_ram_wrt_addrs,
    output logic [DATA_W-1:0] o_ram_wrt_dat,
    output logic              o_ram_wrt_en,
    input  logic [DATA_W-1:0] i_ram_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_fail,
    output logic [ADDR_W-1:0] o_fail_addrs,
    output logic [2:0]        o_fail_elem,
    output logic [DATA_W-1:0] o_fail_data,
    output logic [7:0]        o_fail_cnt
);
    state_t            r_state;
    elem_t             r_elem;
    logic              r_sof, r_pass, r_fail;
    logic [DATA_W-1:0] r_bg, r_fail_data;
    logic [ADDR_W-1:0] r_fail_addrs;
    logic [2:0]        r_fail_elem;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last, w_run, w_start, w_miss, w_halt, w_to_done, w_load, w_step, w_down;
    elem_t             w_elem_nxt;
    assign w_run      = (r_state == WR) || (r_state == RD) || (r_state == CMP);
    assign w_start    = (r_state == IDLE) && i_start && !i_abort;
    assign w_elem_nxt = elem_t'(r_elem + 3'd1);
    assign w_miss     = (r_state == CMP) && (i_ram_rd_data != (ELEM_RVAL[r_elem] ? ~r_bg : r_bg));
    assign w_halt     = w_miss && r_sof;
    // Only E5 ends the run naturally; it is the sole read-only element.
    assign w_to_done  = w_halt || (!ELEM_WR[r_elem] && w_last);
    assign w_load     = w_start || ((r_state == WR) && w_last);
    assign w_step     = !i_abort && (((r_state == WR) && !w_last) || ((r_state == CMP) && !ELEM_WR[r_elem] && !w_to_done));
    assign w_down     = !w_start && ELEM_DOWN[w_elem_nxt];
    bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_down (w_down),
        .i_step (w_step),
        .o_addr (w_addr),
        .o_last (w_last)
    );
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_elem       <= E0;
            r_sof        <= 1'b0;
            r_bg         <= '0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_cnt        <= '0;
            r_fail_addrs <= '0;
            r_fail_elem  <= '0;
            r_fail_data  <= '0;
        end else if (i_abort && w_run) begin
            r_state <= IDLE;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (w_start) begin
                    r_state      <= WR;
                    r_elem       <= E0;
                    r_sof        <= i_stop_on_fail;
                    r_bg         <= i_bg_pat;
                    r_pass       <= 1'b0;
                    r_fail       <= 1'b0;
                    r_cnt        <= '0;
                    r_fail_addrs <= '0;
                    r_fail_elem  <= '0;
                    r_fail_data  <= '0;
                end
                WR: begin
                    // Every element after a write element begins with a read.
                    r_state <= (w_last || ELEM_RD[r_elem]) ? RD : WR;
                    if (w_last) r_elem <= w_elem_nxt;
                end
                RD: r_state <= CMP;
                CMP: begin
                    r_state <= w_to_done ? DONE : ELEM_WR[r_elem] ? WR : RD;
                    if (w_miss) begin
                        if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == 8'h00) begin
                            r_fail_addrs <= w_addr;
                            r_fail_elem  <= r_elem;
                            r_fail_data  <= i_ram_rd_data;
                        end
                    end
                    if (w_to_done) begin
                        r_pass <= !w_miss && (r_cnt == 8'h00);
                        r_fail <= w_miss || (r_cnt != 8'h00);
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_ram_rd_addrs  = w_run ? w_addr : i_usr_rd_addrs;
    assign o_ram_wrt_addrs = w_run ? w_addr : i_usr_wrt_addrs;
    assign o_ram_wrt_dat   = w_run ? (ELEM_WVAL[r_elem] ? ~r_bg : r_bg) : i_usr_wrt_dat;
    assign o_ram_wrt_en    = w_run ? (r_state == WR) : i_usr_wrt_en;
    assign o_busy          = w_run;
    assign o_done          = (r_state == DONE);
    assign o_pass          = r_pass;
    assign o_fail          = r_fail;
    assign o_fail_addrs    = r_fail_addrs;
    assign o_fail_elem     = r_fail_elem;
    assign o_fail_data     = r_fail_data;
    assign o_fail_cnt      = r_cnt;
endmodule

// File: tb/tb_march_bist_ctrl.sv
// tb_march_bist_ctrl: directed self-checking bench for march_bist_ctrl with a faultable RAM model
module tb_march_bist_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, stop_on_fail = 1'b0;
    logic [7:0] bg_pat = 8'h00;
    logic [9:0] usr_rd_addrs = '0, usr_wrt_addrs = '0;
    logic [7:0] usr_wrt_dat = '0;
    logic       usr_wrt_en = 1'b0;
    logic [9:0] ram_rd_addrs, ram_wrt_addrs;
    logic [7:0] ram_wrt_dat, ram_rd_data;
    logic       ram_wrt_en, busy, done, pass, fail;
    logic [9:0] fail_addrs;
    logic [2:0] fail_elem;
    logic [7:0] fail_data, fail_cnt;
    logic [7:0] mem [1024];
    int         fault = 0;
    int         checks = 0, failures = 0;
    int         cyc;
    bit         saw_done;

    always #5 clk = ~clk;

    march_bist_ctrl #(.ADDR_W(10), .DATA_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_stop_on_fail(stop_on_fail), .i_bg_pat(bg_pat),
        .i_usr_rd_addrs(usr_rd_addrs), .i_usr_wrt_addrs(usr_wrt_addrs),
        .i_usr_wrt_dat(usr_wrt_dat), .i_usr_wrt_en(usr_wrt_en),
        .o_ram_rd_addrs(ram_rd_addrs), .o_ram_wrt_addrs(ram_wrt_addrs),
        .o_ram_wrt_dat(ram_wrt_dat), .o_ram_wrt_en(ram_wrt_en),
        .i_ram_rd_data(ram_rd_data), .o_busy(busy), .o_done(done),
        .o_pass(pass), .o_fail(fail), .o_fail_addrs(fail_addrs),
        .o_fail_elem(fail_elem), .o_fail_data(fail_data), .o_fail_cnt(fail_cnt)
    );

    // fault 1: bit 3 stuck-at-0 at 0x2A7 only; fault 2: same fault at every address
    always @(posedge clk) begin
        if (ram_wrt_en) mem[ram_wrt_addrs] <= ram_wrt_dat;
        ram_rd_data <= (fault == 2 || (fault == 1 && ram_rd_addrs == 10'h2A7)) ?
                       (mem[ram_rd_addrs] & 8'hF7) : mem[ram_rd_addrs];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_bist(input int abort_at, input int pulse_at, output int n, output bit seen);
        n = 0;
        seen = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int g = 0; g < 20000; g++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (!busy) break;
            n++;
            start = (n == pulse_at);
            abort = (n == abort_at);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_cnt", fail_cnt, 0);
        chk("rst_we", ram_wrt_en, 0);
        rst = 1'b0;

        bg_pat = 8'h55;
        run_bist(100, 0, cyc, saw_done);
        chk("abort_cyc", cyc, 100);
        chk("abort_done", saw_done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_pass", pass, 0);
        chk("abort_fail", fail, 0);

        usr_wrt_en = 1'b1;
        usr_wrt_addrs = 10'h155;
        usr_wrt_dat = 8'h00;
        run_bist(0, 0, cyc, saw_done);
        chk("ok_cyc", cyc, 15360);
        chk("ok_done", saw_done, 1);
        chk("ok_pass", pass, 1);
        chk("ok_fail", fail, 0);
        chk("ok_cnt", fail_cnt, 0);
        @(negedge clk);
        chk("ok_done_pulse", done, 0);
        chk("ok_idle", busy, 0);
        usr_wrt_en = 1'b0;

        fault = 1;
        bg_pat = 8'h00;
        run_bist(0, 0, cyc, saw_done);
        chk("f1_cyc", cyc, 15360);
        chk("f1_pass", pass, 0);
        chk("f1_fail", fail, 1);
        chk("f1_cnt", fail_cnt, 2);
        chk("f1_elem", fail_elem, 2);
        chk("f1_addr", fail_addrs, 10'h2A7);
        chk("f1_data", fail_data, 8'hF7);

        stop_on_fail = 1'b1;
        run_bist(0, 0, cyc, saw_done);
        chk("sof_cyc", cyc, 6135);
        chk("sof_done", saw_done, 1);
        chk("sof_cnt", fail_cnt, 1);
        chk("sof_fail", fail, 1);
        chk("sof_elem", fail_elem, 2);
        stop_on_fail = 1'b0;

        fault = 2;
        run_bist(0, 500, cyc, saw_done);
        chk("sat_cyc", cyc, 15360);
        chk("sat_cnt", fail_cnt, 255);
        chk("sat_addr", fail_addrs, 10'h000);
        chk("sat_data", fail_data, 8'hF7);

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7300) @(negedge clk);
        chk("e3_busy", busy, 1);
        chk("e3_cnt", fail_cnt, 255);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_fail", fail, 0);
        chk("mid_rst_cnt", fail_cnt, 0);
        chk("mid_rst_addr", fail_addrs, 0);
        chk("mid_rst_elem", fail_elem, 0);
        chk("mid_rst_data", fail_data, 0);
        chk("mid_rst_we", ram_wrt_en, 0);
        @(negedge clk) rst = 1'b0;

        fault = 0;
        usr_wrt_addrs = 10'h3FF;
        usr_wrt_dat = 8'hA5;
        usr_wrt_en = 1'b1;
        #1;
        chk("usr_we", ram_wrt_en, 1);
        chk("usr_wdat", ram_wrt_dat, 8'hA5);
        chk("usr_waddr", ram_wrt_addrs, 10'h3FF);
        @(negedge clk);
        usr_wrt_en = 1'b0;
        usr_rd_addrs = 10'h3FF;
        #1;
        chk("usr_raddr", ram_rd_addrs, 10'h3FF);
        @(negedge clk);
        chk("usr_rdata", ram_rd_data, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/march_bist_ctrl.md
MARCH_BIST_CTRL -- requirements
Module: march_bist_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, RAM address width; depth N = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; begins a March C- run when idle.
REQ-006 abort  in  1  level; terminates a run.
REQ-007 stop_on_fail  in  1  sampled at start; 1 = end run at first miscompare.
REQ-008 bg_pat  in  DATA_W  background pattern "0"; "1" is ~bg_pat; sampled at start.
REQ-009 usr_rd_addrs / usr_wrt_addrs  in  ADDR_W  user port addresses.
REQ-010 usr_wrt_dat  in  DATA_W; usr_wrt_en  in  1  user write port.
REQ-011 ram_rd_addrs / ram_wrt_addrs  out  ADDR_W; ram_wrt_dat  out  DATA_W; ram_wrt_en  out  1  to RAM.
REQ-012 ram_rd_data  in  DATA_W  RAM read data, valid one cycle after ram_rd_addrs.
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); pass  out  1; fail  out  1.
REQ-014 fail_addrs  out  ADDR_W; fail_elem  out  3; fail_data  out  DATA_W: first-miscompare record.
REQ-015 fail_cnt  out  8  miscompare count, saturates at 255.

Function
REQ-016 States SHALL be IDLE, WR, RD, CMP, DONE; element index 0..5 held in a register.
REQ-017 Elements SHALL be: E0 up w0; E1 up r0,w1; E2 up r1,w0; E3 down r0,w1; E4 down r1,w0; E5 down r0.
REQ-018 Per address, a read element SHALL take RD (issue address) -> CMP (compare ram_rd_data against the expected value) -> WR if the element writes, else advance; a write-only element SHALL take WR only.
REQ-019 Address SHALL start at 0 (up) or N-1 (down) and step by 1; leaving the last address of an element SHALL enter the next element's first state on the next cycle with no idle cycle.
REQ-020 A full run SHALL keep busy high for exactly 15*N cycles, then DONE for 1 cycle with done=1, then IDLE.
REQ-021 While busy, RAM ports SHALL be driven by the controller and user inputs ignored; in IDLE, all ram_* outputs SHALL be combinational pass-through of usr_*.
REQ-022 The first miscompare SHALL latch fail_addrs, fail_elem and fail_data (the read value); later miscompares only increment fail_cnt.
REQ-023 With stop_on_fail=1, the cycle after a miscompare SHALL enter DONE.
REQ-024 pass SHALL be set at DONE iff fail_cnt==0; fail = ~pass; both SHALL hold until the next start.
REQ-025 start while busy SHALL be ignored; start in IDLE SHALL clear fail_cnt, pass, fail and the fail record.
REQ-026 abort while busy SHALL return to IDLE the next cycle with done=0, pass=0, fail=0; abort and start in the same cycle: abort wins.

Reset
REQ-027 rst SHALL force IDLE, element 0, address 0, busy=0, done=0, pass=0, fail=0, fail_cnt=0, fail record=0, ram_wrt_en from the controller=0, including mid-run.

Structure
REQ-028 Shared package SHALL hold the state enum, element encoding (E0..E5), element direction/read/write tables, and ADDR_W/DATA_W defaults.
REQ-029 One sub-module SHALL be used: bist_addr_gen (up/down loadable address counter with a last-address flag).

Verification
REQ-030 Fault-free RAM model, N=1024, bg_pat=0x55, start -> busy for 15360 cycles, done pulse, pass=1, fail_cnt=0.
REQ-031 Stuck-at-0 on bit 3 of address 0x2A7, bg_pat=0x00 -> first failure fail_elem=2, fail_addrs=0x2A7, fail_data=0xF7, fail=1.
REQ-032 Same fault, stop_on_fail=1 -> done asserted one cycle after the first miscompare, fail_cnt=1.
REQ-033 abort 100 cycles after start, then start again -> first run gives done=0; second run completes in 15360 cycles.
REQ-034 rst asserted mid-E3 -> all outputs at reset values immediately; user write to 0x3FF with 0xA5 in IDLE, then read -> 0xA5 returned.
REQ-035 start pulsed while busy, and fault on every address -> run length unchanged; fail_cnt saturates at 255.
